// File: rtl/parity_serial_pkg.sv
// Shared types and sizing helpers for the XOR-parity serial receiver.
package parity_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xor_parity_acc.sv
// One-bit running XOR accumulator with a loadable start value.
module xor_parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic init,
    input  logic en,
    input  logic din,
    output logic par_out
);

    always_ff @(posedge clk) begin
        if (rst)
            par_out <= 1'b0;
        else if (clr)
            par_out <= init;
        else if (en)
            par_out <= par_out ^ din;
    end

endmodule

// File: rtl/parity_serial_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, parity, stop.
// Define PARITY_ODD_EN for odd parity; even parity otherwise.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge (and for rx high after a break)
// START  | half a bit period in, confirm the start bit is still low
// DATA   | sample one data bit per bit period, LSB first
// PARITY | sample the parity bit into the accumulator
// STOP   | sample the stop bit and publish the frame
import parity_serial_pkg::*;

module parity_serial_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CYC_W = cnt_w(CLKS_PER_BIT);
    localparam int BIT_W = cnt_w(DATA_W + 1);

`ifdef PARITY_ODD_EN
    localparam logic PAR_INIT = 1'b1;
`else
    localparam logic PAR_INIT = 1'b0;
`endif

    state_t            state, state_nx;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic              brk;
    logic              par;
    logic              half_hit, full_hit;
    logic              cyc_clr, shift_en, acc_clr, acc_en, done;

    assign half_hit = (cyc_cnt == CYC_W'(CLKS_PER_BIT/2 - 1));
    assign full_hit = (cyc_cnt == CYC_W'(CLKS_PER_BIT - 1));
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        cyc_clr  = 1'b0;
        shift_en = 1'b0;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        done     = 1'b0;
        shreg_nx = shreg >> 1;
        shreg_nx[DATA_W-1] = rx;
        case (state)
            IDLE: begin
                cyc_clr = 1'b1;
                if (!brk && !rx) begin
                    state_nx = START;
                    acc_clr  = 1'b1;
                end
            end
            START: begin
                if (half_hit) begin
                    cyc_clr  = 1'b1;
                    state_nx = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_hit) begin
                    cyc_clr  = 1'b1;
                    shift_en = 1'b1;
                    acc_en   = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_W - 1))
                        state_nx = PARITY;
                end
            end
            PARITY: begin
                if (full_hit) begin
                    cyc_clr  = 1'b1;
                    acc_en   = 1'b1;
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (full_hit) begin
                    cyc_clr  = 1'b1;
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            brk        <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            valid   <= done;
            cyc_cnt <= cyc_clr ? '0 : cyc_cnt + CYC_W'(1);
            if (state == IDLE)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + BIT_W'(1);
            if (shift_en)
                shreg <= shreg_nx;
            // A low stop bit marks a break; the line must go high before re-arming.
            if (done) begin
                data_out   <= shreg;
                parity_err <= par;
                frame_err  <= ~rx;
                brk        <= ~rx;
            end else if (rx) begin
                brk <= 1'b0;
            end
        end
    end

    xor_parity_acc u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr),
        .init    (PAR_INIT),
        .en      (acc_en),
        .din     (rx),
        .par_out (par)
    );

endmodule

// File: tb/tb_parity_serial_rx.sv
// Randomised self-checking bench for parity_serial_rx against a frame-level model.
module tb_parity_serial_rx;

    localparam int D   = 8;
    localparam int C   = 16;
    localparam int LAT = (D + 2) * C + C / 2 + 1;

`ifdef PARITY_ODD_EN
    localparam bit ODD = 1'b1;
`else
    localparam bit ODD = 1'b0;
`endif

    typedef struct {
        logic [D-1:0] d;
        logic         pe;
        logic         fe;
        int           t;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx  = 1'b1;
    logic [D-1:0] data_out;
    logic         valid, parity_err, frame_err, busy;

    int     cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    frame_t exp_q[$];
    frame_t got_q[$];

    parity_serial_rx #(.DATA_W(D), .CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (valid) got_q.push_back('{data_out, parity_err, frame_err, cyc});

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic good_pb(input logic [D-1:0] d);
        return (^d) ^ ODD;
    endfunction

    // All driving happens #1 after a rising edge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [D-1:0] d, input logic pb, input logic sb);
        exp_q.push_back('{d, ODD ^ (^d) ^ pb, ~sb, cyc});
        drive_bit(1'b0);
        for (int i = 0; i < D; i++) drive_bit(d[i]);
        drive_bit(pb);
        drive_bit(sb);
    endtask

    task automatic check_frames(input string tag);
        frame_t e, g;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({tag, "_data"},    32'(g.d),  32'(e.d));
            chk({tag, "_par_err"}, 32'(g.pe), 32'(e.pe));
            chk({tag, "_frm_err"}, 32'(g.fe), 32'(e.fe));
            chk({tag, "_latency"}, g.t - e.t, LAT);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [D-1:0] d;
        logic         pb, sb;
        int           gap;
        logic [D-1:0] b2b [4];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",  32'(data_out),   0);
        chk("rst_valid", 32'(valid),      0);
        chk("rst_perr",  32'(parity_err), 0);
        chk("rst_ferr",  32'(frame_err),  0);
        chk("rst_busy",  32'(busy),       0);
        rst = 1'b0;
        idle(4);

        send_frame(8'hA5, good_pb(8'hA5), 1'b1);
        idle(2);
        check_frames("good");

        send_frame(8'h01, 1'b0, 1'b1);
        idle(2);
        check_frames("parity");

        send_frame(8'h3C, good_pb(8'h3C), 1'b0);
        rx = 1'b0;
        repeat (2 * C) @(posedge clk);
        #1;
        idle(C);
        send_frame(8'h55, good_pb(8'h55), 1'b1);
        idle(2);
        check_frames("framing");

        rx = 1'b0;
        for (int i = 1; i <= C / 2 + 1; i++) begin
            if (i == C / 4 + 1) rx = 1'b1;
            @(posedge clk);
            #1;
            if (i == 1)         chk("glitch_busy_hi", 32'(busy), 1);
            if (i == C / 2 + 1) chk("glitch_busy_lo", 32'(busy), 0);
        end
        idle(2 * C);
        check_frames("glitch");

        b2b = '{8'h00, 8'hFF, 8'h80, 8'h7F};
        for (int i = 0; i < 4; i++) send_frame(b2b[i], good_pb(b2b[i]), 1'b1);
        idle(2);
        check_frames("b2b");

        rx = 1'b0;
        repeat (3 * C) @(posedge clk);
        #1;
        rx  = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_valid", 32'(valid), 0);
            chk("midrst_busy",  32'(busy),  0);
        end
        chk("midrst_data", 32'(data_out),   0);
        chk("midrst_perr", 32'(parity_err), 0);
        chk("midrst_ferr", 32'(frame_err),  0);
        rst = 1'b0;
        idle(C);
        check_frames("midrst_none");
        send_frame(8'h5A, good_pb(8'h5A), 1'b1);
        idle(2);
        check_frames("midrst_next");

        for (int k = 0; k < 24; k++) begin
            d   = D'($urandom);
            pb  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : good_pb(d);
            sb  = ($urandom_range(0, 5) != 0);
            send_frame(d, pb, sb);
            gap = sb ? $urandom_range(0, 2 * C) : $urandom_range(2, 2 * C);
            if (gap > 0) idle(gap);
        end
        idle(2);
        check_frames("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
